// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-memory loads/stores, stalls upstream while a
// request is outstanding, aborts on bus timeout and fills the MEM/WB register.
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic [31:0]         ex_alu_out,
  input  logic [31:0]         ex_store_data,
  input  logic [31:0]         ex_pc,
  input  logic [15:0]         ex_imm16,
  input  logic [4:0]          ex_rd,
  input  logic [8:0]          ex_ctrl,
  output logic                mem_stall,
  mem_access_if.master        dmem,
  output logic                wb_valid,
  output logic [31:0]         wb_mem_out,
  output logic [31:0]         wb_alu_out,
  output logic [31:0]         wb_pc,
  output logic [15:0]         wb_imm16,
  output logic [4:0]          wb_rd,
  output logic [6:0]          wb_ctrl,
  output logic [1:0]          err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  // Byte enables for a store; be[3] is the most significant (big-endian) lane.
  function automatic logic [3:0] store_be(input logic is_b, input logic is_h,
                                          input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (is_b) begin
      case (off)
        2'd0:    be = 4'b1000;
        2'd1:    be = 4'b0100;
        2'd2:    be = 4'b0010;
        2'd3:    be = 4'b0001;
        default: be = 4'b0000;
      endcase
    end else if (is_h) begin
      be = off[1] ? 4'b0011 : 4'b1100;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  // Store data replicated across all lanes so the enables pick the right one.
  function automatic logic [31:0] store_lanes(input logic is_b, input logic is_h,
                                              input logic [31:0] data);
    logic [31:0] w;
    if (is_b) begin
      w = {4{data[7:0]}};
    end else if (is_h) begin
      w = {2{data[15:0]}};
    end else begin
      w = data;
    end
    return w;
  endfunction

  // Right-justify the addressed byte/half of the read word, zero-filling above.
  function automatic logic [31:0] load_extract(input logic is_b, input logic is_h,
                                               input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata;
    if (is_b) begin
      case (off)
        2'd0:    v = {24'h000000, rdata[31:24]};
        2'd1:    v = {24'h000000, rdata[23:16]};
        2'd2:    v = {24'h000000, rdata[15:8]};
        2'd3:    v = {24'h000000, rdata[7:0]};
        default: v = 32'h00000000;
      endcase
    end else if (is_h) begin
      v = off[1] ? {16'h0000, rdata[15:0]} : {16'h0000, rdata[31:16]};
    end else begin
      v = rdata;
    end
    return v;
  endfunction

  // Natural alignment: bytes always, halves on even, words on multiples of 4.
  function automatic logic is_aligned(input logic is_b, input logic is_h,
                                      input logic [1:0] off);
    logic ok;
    if (is_b) begin
      ok = 1'b1;
    end else if (is_h) begin
      ok = ~off[0];
    end else begin
      ok = (off == 2'b00);
    end
    return ok;
  endfunction

  // Instruction decode. A write overrides a simultaneous read.
  logic       wr_s;
  logic       rd_s;
  logic       size_b_s;
  logic       size_h_s;
  logic       memop_s;
  logic       aligned_s;
  logic [6:0] wb_ctrl_s;

  assign wr_s      = ex_ctrl[1];
  assign rd_s      = ex_ctrl[0] & ~ex_ctrl[1];
  assign size_b_s  = ex_ctrl[2];
  assign size_h_s  = ~ex_ctrl[2] & ex_ctrl[3];
  assign memop_s   = ex_valid & (ex_ctrl[0] | ex_ctrl[1]);
  assign aligned_s = is_aligned(size_b_s, size_h_s, ex_alu_out[1:0]);
  assign wb_ctrl_s = {ex_ctrl[8], ex_ctrl[4], rd_s & size_h_s, rd_s & size_b_s,
                      ex_ctrl[7], ex_ctrl[6], ex_ctrl[5]};

  state_t         state_r;
  state_t         state_next_s;
  logic [CW-1:0]  cnt_r;
  logic           accept_s;
  logic           misalign_s;
  logic           pass_s;
  logic           done_s;
  logic           abort_s;

  // Transaction context held for the duration of an access.
  logic [31:0]    lat_alu_r;
  logic [31:0]    lat_pc_r;
  logic [15:0]    lat_imm_r;
  logic [4:0]     lat_rd_r;
  logic [6:0]     lat_ctrl_r;
  logic           lat_read_r;
  logic           lat_b_r;
  logic           lat_h_r;

  // Registered bus and MEM/WB outputs.
  logic           req_r;
  logic           we_r;
  logic [31:0]    addr_r;
  logic [31:0]    wdata_r;
  logic [3:0]     be_r;
  logic           wb_valid_r;
  logic [31:0]    wb_mem_out_r;
  logic [31:0]    wb_alu_out_r;
  logic [31:0]    wb_pc_r;
  logic [15:0]    wb_imm16_r;
  logic [4:0]     wb_rd_r;
  logic [6:0]     wb_ctrl_r;
  logic [1:0]     err_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, per-cycle actions and the combinational stall.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    misalign_s   = 1'b0;
    pass_s       = 1'b0;
    done_s       = 1'b0;
    abort_s      = 1'b0;
    mem_stall    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (memop_s && aligned_s) begin
          accept_s     = 1'b1;
          mem_stall    = 1'b1;
          state_next_s = ST_ACCESS;
        end else if (memop_s) begin
          misalign_s   = 1'b1;
        end else if (ex_valid) begin
          pass_s       = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (dmem.dmem_ack) begin
          done_s       = 1'b1;
          state_next_s = ST_IDLE;
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          abort_s      = 1'b1;
          mem_stall    = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          mem_stall    = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Bus request, timeout counter and captured transaction context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= 32'h00000000;
      wdata_r    <= 32'h00000000;
      be_r       <= 4'b0000;
      cnt_r      <= '0;
      lat_alu_r  <= 32'h00000000;
      lat_pc_r   <= 32'h00000000;
      lat_imm_r  <= 16'h0000;
      lat_rd_r   <= 5'd0;
      lat_ctrl_r <= 7'd0;
      lat_read_r <= 1'b0;
      lat_b_r    <= 1'b0;
      lat_h_r    <= 1'b0;
    end else if (accept_s) begin
      req_r      <= 1'b1;
      we_r       <= wr_s;
      addr_r     <= {ex_alu_out[31:2], 2'b00};
      wdata_r    <= store_lanes(size_b_s, size_h_s, ex_store_data);
      be_r       <= store_be(size_b_s, size_h_s, ex_alu_out[1:0]);
      cnt_r      <= '0;
      lat_alu_r  <= ex_alu_out;
      lat_pc_r   <= ex_pc;
      lat_imm_r  <= ex_imm16;
      lat_rd_r   <= ex_rd;
      lat_ctrl_r <= wb_ctrl_s;
      lat_read_r <= rd_s;
      lat_b_r    <= size_b_s;
      lat_h_r    <= size_h_s;
    end else if (done_s || abort_s) begin
      req_r      <= 1'b0;
    end else if (state_r == ST_ACCESS) begin
      cnt_r      <= cnt_r + CW'(1);
    end
  end

  // MEM/WB register and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_r   <= 1'b0;
      wb_mem_out_r <= 32'h00000000;
      wb_alu_out_r <= 32'h00000000;
      wb_pc_r      <= 32'h00000000;
      wb_imm16_r   <= 16'h0000;
      wb_rd_r      <= 5'd0;
      wb_ctrl_r    <= 7'd0;
      err_r        <= 2'b00;
    end else begin
      err_r      <= {abort_s, misalign_s};
      wb_valid_r <= pass_s | done_s;
      if (pass_s) begin
        wb_mem_out_r <= 32'h00000000;
        wb_alu_out_r <= ex_alu_out;
        wb_pc_r      <= ex_pc;
        wb_imm16_r   <= ex_imm16;
        wb_rd_r      <= ex_rd;
        wb_ctrl_r    <= wb_ctrl_s;
      end else if (done_s) begin
        wb_mem_out_r <= lat_read_r ?
                        load_extract(lat_b_r, lat_h_r, lat_alu_r[1:0], dmem.dmem_rdata) :
                        32'h00000000;
        wb_alu_out_r <= lat_alu_r;
        wb_pc_r      <= lat_pc_r;
        wb_imm16_r   <= lat_imm_r;
        wb_rd_r      <= lat_rd_r;
        wb_ctrl_r    <= lat_ctrl_r;
      end
    end
  end

  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;
  assign dmem.dmem_be    = be_r;
  assign wb_valid        = wb_valid_r;
  assign wb_mem_out      = wb_mem_out_r;
  assign wb_alu_out      = wb_alu_out_r;
  assign wb_pc           = wb_pc_r;
  assign wb_imm16        = wb_imm16_r;
  assign wb_rd           = wb_rd_r;
  assign wb_ctrl         = wb_ctrl_r;
  assign err             = err_r;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: a driver acts as pipeline and memory,
// pushing expected MEM/WB results and bus transactions that monitors check.
module tb_mem_access;
  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic [15:0] ex_imm16;
  logic [4:0]  ex_rd;
  logic [8:0]  ex_ctrl;
  logic        mem_stall;
  logic        wb_valid;
  logic [31:0] wb_mem_out;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_pc;
  logic [15:0] wb_imm16;
  logic [4:0]  wb_rd;
  logic [6:0]  wb_ctrl;
  logic [1:0]  err;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm16(ex_imm16),
    .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .mem_stall(mem_stall), .dmem(bus),
    .wb_valid(wb_valid), .wb_mem_out(wb_mem_out), .wb_alu_out(wb_alu_out),
    .wb_pc(wb_pc), .wb_imm16(wb_imm16), .wb_rd(wb_rd), .wb_ctrl(wb_ctrl),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = MEM/WB write-back, 1 = misalign error, 2 = timeout error
  typedef struct {
    int          kind;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] mem;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic [6:0]  ctrl;
    bit          chk_mem;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cycles;
  } bus_exp_t;

  wb_exp_t  exp_q[$];
  bus_exp_t bus_q[$];
  int       tests = 0;
  int       fails = 0;
  bit       mon_en = 1'b0;
  int       bus_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result monitor: every write-back or error pulse must match the queue head.
  always @(negedge clk) begin
    wb_exp_t w;
    if (rst_n && mon_en) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb_valid", 32'(wb_valid), 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("wb_kind", 32'(0), 32'(w.kind));
          check("wb_alu_out", wb_alu_out, w.alu);
          check("wb_pc", wb_pc, w.pc);
          check("wb_imm16", 32'(wb_imm16), 32'(w.imm));
          check("wb_rd", 32'(wb_rd), 32'(w.rd));
          check("wb_ctrl", 32'(wb_ctrl), 32'(w.ctrl));
          if (w.chk_mem) check("wb_mem_out", wb_mem_out, w.mem);
        end
      end
      if (err != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_err", 32'(err), 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("err", 32'(err), (w.kind == 1) ? 32'd1 : (w.kind == 2) ? 32'd2 : 32'd0);
        end
      end
    end
  end

  // Bus monitor: each request-high cycle must show the expected, stable request.
  always @(negedge clk) begin
    if (rst_n && mon_en && bus.dmem_req) begin
      if (bus_q.size() == 0) begin
        check("unexpected_dmem_req", 32'(bus.dmem_req), 32'd0);
      end else begin
        check("dmem_we", 32'(bus.dmem_we), 32'(bus_q[0].we));
        check("dmem_addr", bus.dmem_addr, bus_q[0].addr);
        check("dmem_be", 32'(bus.dmem_be), 32'(bus_q[0].be));
        if (bus_q[0].we) check("dmem_wdata", bus.dmem_wdata, bus_q[0].wdata);
        bus_cnt++;
        if (bus_cnt == bus_q[0].cycles) begin
          void'(bus_q.pop_front());
          bus_cnt = 0;
        end
      end
    end
  end

  task automatic cycle(input logic exp_stall);
    @(negedge clk);
    check("mem_stall", 32'(mem_stall), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, play the memory side, and push what must come out.
  // delay >= TO means the memory never answers.
  task automatic issue(input logic [8:0] ctrl, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] rdata, input int delay);
    logic wr, rdd, isb, ish, memop, al, tmo;
    int off;
    wb_exp_t w;
    bus_exp_t b;
    wr    = ctrl[1];
    rdd   = ctrl[0] && !wr;
    isb   = ctrl[2];
    ish   = !isb && ctrl[3];
    memop = wr || ctrl[0];
    off   = int'(alu[1:0]);
    al    = isb ? 1'b1 : ish ? (off % 2 == 0) : (off == 0);
    tmo   = (delay >= TO);

    ex_valid = 1'b1; ex_ctrl = ctrl; ex_alu_out = alu; ex_store_data = sd;
    ex_pc = $urandom; ex_imm16 = 16'($urandom); ex_rd = 5'($urandom);

    w.alu = alu; w.pc = ex_pc; w.imm = ex_imm16; w.rd = ex_rd;
    w.ctrl = {ctrl[8], ctrl[4], rdd & ish, rdd & isb, ctrl[7], ctrl[6], ctrl[5]};
    w.chk_mem = rdd;
    if (isb)      w.mem = (rdata >> (8 * (3 - off))) & 32'h000000FF;
    else if (ish) w.mem = (rdata >> ((off >= 2) ? 0 : 16)) & 32'h0000FFFF;
    else          w.mem = rdata;

    if (!memop) begin
      w.kind = 0; exp_q.push_back(w);
      cycle(1'b0);
    end else if (!al) begin
      w.kind = 1; exp_q.push_back(w);
      cycle(1'b0);
    end else begin
      b.we     = wr;
      b.addr   = alu & 32'hFFFFFFFC;
      b.be     = isb ? 4'(1 << (3 - off)) : ish ? ((off >= 2) ? 4'd3 : 4'd12) : 4'd15;
      b.wdata  = isb ? (sd & 32'hFF) * 32'h01010101 :
                 ish ? (sd & 32'hFFFF) * 32'h00010001 : sd;
      b.cycles = tmo ? TO : delay + 1;
      bus_q.push_back(b);
      w.kind = tmo ? 2 : 0; exp_q.push_back(w);
      cycle(1'b1);
      for (int i = 0; i < b.cycles; i++) begin
        bus.dmem_ack   = !tmo && (i == delay);
        bus.dmem_rdata = bus.dmem_ack ? rdata : $urandom;
        cycle(!bus.dmem_ack);
      end
      bus.dmem_ack = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] c;
    int r, d;
    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_out = 32'd0; ex_store_data = 32'd0;
    ex_pc = 32'd0; ex_imm16 = 16'd0; ex_rd = 5'd0; ex_ctrl = 9'd0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    #12;
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wb_alu_out", wb_alu_out, 32'd0);
    check("rst_mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;

    // Directed cases: ALU pass-through, lb, sh with delayed ack, misaligned lw,
    // timeout and ack exactly on the last allowed cycle.
    issue(9'h100, 32'h00001234, 32'd0, 32'd0, 0);
    issue(9'h125, 32'h00000102, 32'd0, 32'hAABBCCDD, 0);
    issue(9'h00A, 32'h00000206, 32'h0000BEEF, 32'd0, 1);
    issue(9'h121, 32'h00000301, 32'd0, 32'd0, 0);
    issue(9'h121, 32'h00000400, 32'd0, 32'h12345678, 99);
    issue(9'h121, 32'h00000404, 32'd0, 32'h87654321, TO - 1);
    issue(9'h123, 32'h00000503, 32'h000000A5, 32'd0, 0);

    // Randomized mix of ALU ops, loads, stores, bubbles and bus delays.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ex_valid = 1'b0;
        cycle(1'b0);
      end else begin
        c = 9'($urandom) & 9'h1F0;
        c = c | 9'($urandom_range(0, 3)) | (9'($urandom_range(0, 3)) << 2);
        r = $urandom_range(0, 19);
        d = (r < 14) ? r % 4 : (r < 17) ? 99 : TO - 1;
        issue(c, $urandom, $urandom, $urandom, d);
      end
    end
    ex_valid = 1'b0;
    cycle(1'b0);
    cycle(1'b0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);

    // Reset in the middle of an access, then a stray ack after release.
    mon_en = 1'b0;
    ex_valid = 1'b1; ex_ctrl = 9'h121; ex_alu_out = 32'h00000600;
    cycle(1'b1);
    @(negedge clk);
    check("req_before_rst", 32'(bus.dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    ex_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mon_en = 1'b1;
    bus.dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      check("stray_ack_req", 32'(bus.dmem_req), 32'd0);
    end
    bus.dmem_ack = 1'b0;
    issue(9'h100, 32'h0000CAFE, 32'd0, 32'd0, 0);
    cycle(1'b0);
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_bus_q_empty", 32'(bus_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of ACCESS-state cycles without dmem_ack before a transaction is aborted.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid  in  1  EX/MEM holds a valid instruction.
REQ-005 ex_alu_out  in  32  ALU result / effective address.
REQ-006 ex_store_data  in  32  store source register value.
REQ-007 ex_pc  in  32  instruction PC.
REQ-008 ex_imm16  in  16  immediate, for lhi.
REQ-009 ex_rd  in  5  destination register.
REQ-010 ex_ctrl  in  9  [0]mem_read [1]mem_write [2]size_b [3]size_h [4]load_extend [5]mem_to_reg [6]lhi [7]link [8]reg_write.
REQ-011 mem_stall  out  1  upstream SHALL hold ex_* stable and issue nothing new while high.
REQ-012 dmem_req  out  1  data-memory request, registered.
REQ-013 dmem_we  out  1  1 = write.
REQ-014 dmem_addr  out  32  word address, bits [1:0] forced 0.
REQ-015 dmem_wdata  out  32  lane-placed store data.
REQ-016 dmem_be  out  4  byte enables, be[3] = bits 31:24.
REQ-017 dmem_ack  in  1  completes the request in the cycle it is sampled high.
REQ-018 dmem_rdata  in  32  read data, valid with dmem_ack.
REQ-019 wb_valid  out  1  MEM/WB register holds a valid instruction.
REQ-020 wb_mem_out  out  32  loaded value, right-justified, upper bits zero for lb/lh.
REQ-021 wb_alu_out  out  32  registered ex_alu_out.
REQ-022 wb_pc  out  32  registered ex_pc.
REQ-023 wb_imm16  out  16  registered ex_imm16.
REQ-024 wb_rd  out  5  registered ex_rd.
REQ-025 wb_ctrl  out  7  [0]mem_to_reg [1]lhi [2]link [3]lb [4]lh [5]load_extend [6]reg_write.
REQ-026 err  out  2  one-cycle pulses: [0] misaligned access, [1] bus timeout.

Function
REQ-027 Memory op = ex_valid & (mem_read | mem_write). mem_write SHALL take priority when both are set; mem_read is then ignored and lb/lh are 0.
REQ-028 Alignment: byte always aligned; half requires addr[0]=0; word requires addr[1:0]=0.
REQ-029 FSM states IDLE and ACCESS. IDLE + aligned memory op: latch inputs, go ACCESS, assert dmem_req next cycle. Any other ex_valid: load MEM/WB in one cycle.
REQ-030 ACCESS: dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be SHALL stay constant until ack or abort. On dmem_ack: capture rdata, load MEM/WB, wb_valid=1, deassert dmem_req, return to IDLE.
REQ-031 mem_stall = (IDLE & aligned memory op) | (ACCESS & ~dmem_ack), combinational. wb_valid SHALL be 0 on every stalled cycle (bubble).
REQ-032 Minimum memory-op latency is 2 cycles from acceptance to wb_valid, with ack in the first ACCESS cycle. Non-memory latency is 1 cycle.
REQ-033 Store lanes are big-endian. sb replicates the byte to all lanes, be = 4'b1000 >> addr[1:0]. sh replicates the half, be = addr[1] ? 0011 : 1100. sw uses be = 1111.
REQ-034 Load extraction: lb takes rdata byte (3-addr[1:0]) into [7:0]. lh takes the half selected by addr[1] (0 = upper) into [15:0]. Upper bits are zero; the sign extension is done downstream.
REQ-035 Misaligned memory op: no request issued, err[0] pulsed the next cycle, instruction dropped (wb_valid=0), no stall.
REQ-036 Timeout counter clears on entering ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT: drop dmem_req, pulse err[1], drop the instruction, go IDLE. Ack in the same cycle as expiry wins.
REQ-037 dmem_ack while not in ACCESS SHALL be ignored.

Reset
REQ-038 rst_n low SHALL immediately force IDLE, and all outputs and the counter to 0 (dmem_req drops mid-transaction, which is abandoned). Normal operation resumes on the first edge after release.

Verification
REQ-039 ALU op, ex_alu_out=0x1234, reg_write=1 -> next cycle wb_valid=1, wb_alu_out=0x1234, mem_stall never high.
REQ-040 lb addr 0x102, ack in first ACCESS cycle with rdata=0xAABBCCDD -> dmem_addr=0x100, be=0010, wb_mem_out=0x000000CC, wb_ctrl[3]=1.
REQ-041 sh addr 0x206, store_data=0x0000BEEF -> dmem_we=1, be=0011, wdata=0xBEEFBEEF; mem_stall high for 2 cycles with 1-cycle ack delay.
REQ-042 lw addr 0x301 -> err[0] pulse, dmem_req stays 0, wb_valid=0.
REQ-043 lw with no ack, TIMEOUT=16 -> dmem_req held 16 cycles, then err[1] pulse, IDLE, stall released. A repeat with ack on cycle 16 -> normal completion, no err.
REQ-044 rst_n low during ACCESS -> dmem_req=0 asynchronously, wb_valid=0. A later stray ack is ignored.
